// File: rtl/div_signed_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents: FSM state enum, default width, iteration count, quotient limits
// for the default width, and a two's-complement magnitude helper.
package div_signed_pkg;

  localparam int unsigned DIV_DW   = 8;
  localparam int unsigned DIV_ITER = 2 * DIV_DW;

  localparam logic [DIV_DW-1:0] QMAX = {1'b0, {(DIV_DW-1){1'b1}}};
  localparam logic [DIV_DW-1:0] QMIN = {1'b1, {(DIV_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Magnitude of a sign-extended 32-bit value; the most negative operand of any
  // narrower width still yields its correct unsigned magnitude.
  function automatic logic [31:0] abs_u32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude if it fits, emit the quotient bit.
// Ports:
//   prem_i  partial remainder in (DW+1 bits)
//   bit_i   next dividend magnitude bit (MSB first)
//   dvs_i   divisor magnitude
//   prem_o  partial remainder out
//   qbit_o  quotient bit produced by this step
module div_restore_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW:0]   prem_i,
  input  logic          bit_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW:0]   prem_o,
  output logic          qbit_o
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] dvs_ext;

  // Compare/subtract on a one-bit-wider copy so no shifted-out bit is lost.
  always_comb begin
    shifted = {prem_i, bit_i};
    dvs_ext = (DW+2)'(dvs_i);
    qbit_o  = (shifted >= dvs_ext);
    prem_o  = qbit_o ? (DW+1)'(shifted - dvs_ext) : (DW+1)'(shifted);
  end

endmodule

// File: rtl/div_signed_16by8_seq.sv
// Sequential signed divider: 2*DW-bit signed dividend / DW-bit signed divisor.
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Restoring shift-subtract on magnitudes, one bit per cycle, sign fix at end.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   dividend, divisor     signed operands, sampled on the accepting edge
//   out_valid / out_ready result handshake; results held until accepted
//   quotient, remainder   signed results
//   ovf                   true quotient does not fit in DW signed bits
//   dbz                   divisor was zero (quotient all ones, remainder = dividend low bits)
// Build option: define DIV_SIGNED_SAT_EN to saturate the quotient on ovf
// instead of wrapping to its low DW bits.
module div_signed_16by8_seq
  import div_signed_pkg::*;
#(
  parameter int unsigned DW = DIV_DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            ovf,
  output logic            dbz
);

  localparam int unsigned ITER = 2 * DW;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned PW   = DW + 1;

  localparam logic [DW-1:0]   Q_MAX       = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   Q_MIN       = {1'b1, {(DW-1){1'b0}}};
  localparam logic [2*DW-1:0] MAG_POS_MAX = (2*DW)'((1 << (DW-1)) - 1);
  localparam logic [2*DW-1:0] MAG_NEG_MAX = (2*DW)'(1 << (DW-1));

  div_state_e      state_q;
  logic [2*DW-1:0] dvd_q;       // dividend magnitude, becomes quotient magnitude
  logic [DW-1:0]   dvs_q;
  logic [PW-1:0]   prem_q;
  logic            dvd_sign_q;
  logic            dvs_sign_q;
  logic            dbz_q;
  logic [CW-1:0]   cnt_q;

  logic [PW-1:0]   prem_d;
  logic            qbit_d;
  logic            accept;
  logic [2*DW-1:0] dvd_abs;
  logic [DW-1:0]   dvs_abs;

  logic            fix_neg;
  logic            fix_ovf;
  logic [DW-1:0]   fix_q;
  logic [DW-1:0]   fix_r;
  logic [DW-1:0]   q_wrap;
  logic [DW-1:0]   r_mag;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign dvd_abs  = (2*DW)'(abs_u32(32'($signed(dividend))));
  assign dvs_abs  = DW'(abs_u32(32'($signed(divisor))));

  div_restore_step #(.DW(DW)) u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[2*DW-1]),
    .dvs_i  (dvs_q),
    .prem_o (prem_d),
    .qbit_o (qbit_d)
  );

  // Sign fix, overflow detection and divide-by-zero substitution.
  always_comb begin
    fix_neg = dvd_sign_q ^ dvs_sign_q;
    fix_ovf = 1'b0;
    q_wrap  = dvd_q[DW-1:0];
    r_mag   = prem_q[DW-1:0];
    fix_q   = '0;
    fix_r   = '0;
    if (dbz_q) begin
      fix_q = '1;
      fix_r = dvd_q[DW-1:0];
    end else begin
      // A negative result may reach one further magnitude than a positive one.
      fix_ovf = fix_neg ? (dvd_q > MAG_NEG_MAX) : (dvd_q > MAG_POS_MAX);
      // Low bits of a negation depend only on low bits of the operand.
      q_wrap  = fix_neg ? (~dvd_q[DW-1:0] + DW'(1)) : dvd_q[DW-1:0];
`ifdef DIV_SIGNED_SAT_EN
      fix_q   = fix_ovf ? (fix_neg ? Q_MIN : Q_MAX) : q_wrap;
`else
      fix_q   = q_wrap;
`endif
      fix_r   = dvd_sign_q ? (~r_mag + DW'(1)) : r_mag;
    end
  end

  // Control FSM with operand, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      dvd_sign_q <= 1'b0;
      dvs_sign_q <= 1'b0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      ovf        <= 1'b0;
      dbz        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_sign_q <= dividend[2*DW-1];
            dvs_sign_q <= divisor[DW-1];
            dvs_q      <= dvs_abs;
            prem_q     <= '0;
            cnt_q      <= '0;
            if (divisor == '0) begin
              // Raw dividend kept so its low bits can be returned as remainder.
              dbz_q   <= 1'b1;
              dvd_q   <= dividend;
              state_q <= FIX;
            end else begin
              dbz_q   <= 1'b0;
              dvd_q   <= dvd_abs;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= {dvd_q[2*DW-2:0], qbit_d};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient  <= fix_q;
          remainder <= fix_r;
          ovf       <= fix_ovf;
          dbz       <= dbz_q;
          out_valid <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
